// File: rtl/instr_queue.sv
// Circular FIFO of {pc, ir} pairs between fetch and decode/dispatch.
// Head entry is presented combinationally; status flags come from the registered count only.
module instr_queue #(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             enq,
   input  logic [15:0]      ir_in,
   input  logic [15:0]      pc_in,
   input  logic             deq,
   output logic [15:0]      ir_out,
   output logic [15:0]      pc_out,
   output logic             valid_out,
   output logic             empty,
   output logic             full,
   output logic             stall_fetch,
   output logic [PTR_W:0]   count
);

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             do_enq;
   logic             do_deq;

   always_comb begin
      empty       = (count == '0);
      full        = (count == (PTR_W+1)'(DEPTH));
      valid_out   = ~empty;
      stall_fetch = full;
      do_deq      = deq & ~empty;
      // A full queue still accepts a write when the head leaves in the same cycle.
      do_enq      = enq & (~full | do_deq);
      {pc_out, ir_out} = mem[head];
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_enq)
            tail <= tail + PTR_W'(1);
         if (do_deq)
            head <= head + PTR_W'(1);
         count <= count + (PTR_W+1)'(do_enq) - (PTR_W+1)'(do_deq);
      end
   end

   // Storage is not reset; contents are only observable through the head when count > 0.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_enq)
         mem[tail] <= {pc_in, ir_in};
   end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: table vectors, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_instr_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        enq = 1'b0;
   logic        deq = 1'b0;
   logic [15:0] ir_in = '0;
   logic [15:0] pc_in = '0;
   logic [15:0] ir_out;
   logic [15:0] pc_out;
   logic        valid_out;
   logic        empty;
   logic        full;
   logic        stall_fetch;
   logic [3:0]  count;

   int errors = 0;
   int checks = 0;

   logic [31:0] mq[$];

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .enq(enq), .ir_in(ir_in), .pc_in(pc_in),
      .deq(deq), .ir_out(ir_out), .pc_out(pc_out), .valid_out(valid_out),
      .empty(empty), .full(full), .stall_fetch(stall_fetch), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          r, f, e, d;
      logic [15:0] pc, ir;
      int          exp_count;
      bit          exp_valid;
      logic [15:0] exp_pc, exp_ir;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Occupancy bound, sampled away from the active edge every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (count > 4'(DEPTH) || ^count === 1'bx) begin
            errors++;
            $display("FAIL bound: count=%0d exceeds %0d", count, DEPTH);
         end
      end
   end

   // Reference model: queue semantics computed from the accept/take rules.
   task automatic model_edge(input bit r, f, e, d, input logic [15:0] p, i);
      bit take, put;
      if (r || f) begin
         mq.delete();
      end else begin
         take = d && (mq.size() > 0);
         put  = e && ((mq.size() < DEPTH) || take);
         if (take) void'(mq.pop_front());
         if (put)  mq.push_back({p, i});
      end
   endtask

   task automatic compare_model();
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
      chk("stall_fetch", 32'(stall_fetch), 32'(mq.size() == DEPTH));
      if (mq.size() > 0) begin
         chk("pc_out", 32'(pc_out), 32'(mq[0][31:16]));
         chk("ir_out", 32'(ir_out), 32'(mq[0][15:0]));
      end
   endtask

   task automatic step(input bit r, f, e, d, input logic [15:0] p, i);
      rst = r; flush = f; enq = e; deq = d; pc_in = p; ir_in = i;
      @(posedge clk);
      model_edge(r, f, e, d, p, i);
      #1;
      compare_model();
   endtask

   task automatic fill_to(input int n, input logic [15:0] pc0);
      for (int k = 0; k < n; k++)
         step(0, 0, 1, 0, pc0 + 16'(2 * k), 16'($urandom));
   endtask

   vec_t vt[10];

   initial begin
      vt[0] = '{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000};
      vt[1] = '{0, 0, 1, 0, 16'h0000, 16'h1234, 1, 1, 16'h0000, 16'h1234};
      vt[2] = '{0, 0, 1, 0, 16'h0002, 16'h5678, 2, 1, 16'h0000, 16'h1234};
      vt[3] = '{0, 0, 1, 0, 16'h0004, 16'h9ABC, 3, 1, 16'h0000, 16'h1234};
      vt[4] = '{0, 0, 0, 1, 16'h0000, 16'h0000, 2, 1, 16'h0002, 16'h5678};
      vt[5] = '{0, 0, 1, 1, 16'h0006, 16'h1111, 2, 1, 16'h0004, 16'h9ABC};
      vt[6] = '{0, 1, 1, 1, 16'h0008, 16'h2222, 0, 0, 16'h0000, 16'h0000};
      vt[7] = '{0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000};
      vt[8] = '{0, 0, 1, 1, 16'h0040, 16'h4040, 1, 1, 16'h0040, 16'h4040};
      vt[9] = '{1, 0, 1, 1, 16'h0050, 16'h5050, 0, 0, 16'h0000, 16'h0000};

      repeat (2) @(posedge clk);

      for (int k = 0; k < 10; k++) begin
         step(vt[k].r, vt[k].f, vt[k].e, vt[k].d, vt[k].pc, vt[k].ir);
         chk($sformatf("vec%0d count", k), 32'(count), 32'(vt[k].exp_count));
         chk($sformatf("vec%0d valid", k), 32'(valid_out), 32'(vt[k].exp_valid));
         if (vt[k].exp_valid) begin
            chk($sformatf("vec%0d pc", k), 32'(pc_out), 32'(vt[k].exp_pc));
            chk($sformatf("vec%0d ir", k), 32'(ir_out), 32'(vt[k].exp_ir));
         end
      end

      // Fill to full, drop a 9th enq, drain in order.
      step(1, 0, 0, 0, 0, 0);
      fill_to(8, 16'h0000);
      chk("fill full", 32'(full), 32'd1);
      chk("fill stall", 32'(stall_fetch), 32'd1);
      step(0, 0, 1, 0, 16'h0010, 16'hDEAD);
      chk("drop count", 32'(count), 32'd8);
      for (int k = 0; k < 8; k++) begin
         chk("drain pc", 32'(pc_out), 32'(2 * k));
         step(0, 0, 0, 1, 0, 0);
      end
      chk("drain empty", 32'(empty), 32'd1);

      // Full queue with simultaneous enq+deq.
      fill_to(8, 16'h0000);
      step(0, 0, 1, 1, 16'h0020, 16'hBEEF);
      chk("full swap count", 32'(count), 32'd8);
      chk("full swap head", 32'(pc_out), 32'h0002);
      for (int k = 0; k < 8; k++) begin
         chk("swap drain pc", 32'(pc_out), (k == 7) ? 32'h0020 : 32'(2 * k + 2));
         step(0, 0, 0, 1, 0, 0);
      end

      // Empty queue with simultaneous enq+deq: enq wins, deq ignored.
      step(0, 0, 1, 1, 16'h0040, 16'h0404);
      chk("empty swap count", 32'(count), 32'd1);
      chk("empty swap pc", 32'(pc_out), 32'h0040);

      // Wrap-around with continuous enq+deq after priming two entries.
      step(1, 0, 0, 0, 0, 0);
      fill_to(2, 16'h0200);
      for (int k = 0; k < 20; k++) begin
         chk("wrap head", 32'(pc_out), 32'(16'h0200 + 16'(2 * k)));
         step(0, 0, 1, 1, 16'h0204 + 16'(2 * k), 16'($urandom));
         chk("wrap count", 32'(count), 32'd2);
      end

      // Flush and reset mid-stream, each followed by a fresh enq.
      for (int m = 0; m < 2; m++) begin
         step(1, 0, 0, 0, 0, 0);
         fill_to(5, 16'h0300);
         step(m == 1, m == 0, 1, 1, 16'h0999, 16'h9999);
         chk("clear count", 32'(count), 32'd0);
         chk("clear empty", 32'(empty), 32'd1);
         step(0, 0, 1, 0, 16'h0100, 16'h0101);
         chk("post-clear pc", 32'(pc_out), 32'h0100);
         chk("post-clear valid", 32'(valid_out), 32'd1);
      end

      // Randomized traffic with phases biased toward filling and draining.
      for (int c = 0; c < 3000; c++) begin
         int pe, pd;
         pe = ((c / 150) % 2 == 0) ? 75 : 35;
         pd = ((c / 150) % 2 == 0) ? 35 : 75;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < pe, $urandom_range(0, 99) < pd,
              16'($urandom), 16'($urandom));
      end

      rst = 1'b0; flush = 1'b0; enq = 1'b0; deq = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
